// File: rtl/ssd_scan_decoder_if.sv
// Bundle of scanned-display inputs and decoded frame outputs.
// Latency: none, wires only.
// Backpressure: none; the scan source free-runs and frames are pulsed out.
interface ssd_scan_decoder_if;
    logic [7:0]  D_ssd;       // active-low segments a..g, dp (bit7..bit0)
    logic [3:0]  D_ctl;       // active-low digit enables
    logic [15:0] bcd_out;     // last complete frame, digit n in [4n+3:4n]
    logic [3:0]  dp_out;      // decimal points of the last frame, active-high
    logic        frame_done;  // one-cycle pulse on frame update
    logic        seg_err;     // sticky: unrecognised pattern captured
    logic        no_signal;   // scan considered lost

    // Scan source / consumer side.
    modport master (
        output D_ssd, D_ctl,
        input  bcd_out, dp_out, frame_done, seg_err, no_signal
    );

    // Decoder side.
    modport slave (
        input  D_ssd, D_ctl,
        output bcd_out, dp_out, frame_done, seg_err, no_signal
    );
endinterface

// File: rtl/ssd_scan_decoder.sv
// Recovers 4-digit BCD + decimal points from a multiplexed 7-segment scan.
// Latency: frame_done rises STABLE_CYC+2 cycles after the 4th digit appears at the inputs.
// Backpressure: none; the scan cannot be stalled, frames are presented as a pulse.
module ssd_scan_decoder #(
    parameter int unsigned STABLE_CYC  = 4,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    ssd_scan_decoder_if.slave bus
);

    localparam logic [7:0]  STABLE_W  = 8'(STABLE_CYC);
    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT_CYC);

    typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

    // Segment pattern (a..g, active-low) to BCD code; 4'hF blank, 4'hE unknown.
    function automatic logic [3:0] seg_decode(input logic [6:0] s);
        logic [3:0] code;
        case (s)
            7'b0000001: code = 4'h0;
            7'b1001111: code = 4'h1;
            7'b0010010: code = 4'h2;
            7'b0000110: code = 4'h3;
            7'b1001100: code = 4'h4;
            7'b0100100: code = 4'h5;
            7'b0100000: code = 4'h6;
            7'b0001111: code = 4'h7;
            7'b0000000: code = 4'h8;
            7'b0000100: code = 4'h9;
            7'b1111111: code = 4'hF;
            default:    code = 4'hE;
        endcase
        return code;
    endfunction

    logic [7:0]  ssd_s1_q, ssd_s2_q;
    logic [3:0]  ctl_s1_q, ctl_s2_q;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  pat_q, pat_d;
    logic [15:0] stg_code_q, stg_code_d;
    logic [3:0]  stg_dp_q, stg_dp_d;
    logic [3:0]  cap_q, cap_d;
    logic [15:0] nosel_q, nosel_d;
    logic [15:0] bcd_q, bcd_d;
    logic [3:0]  dp_q, dp_d;
    logic        fd_q, fd_d;
    logic        err_q, err_d;
    logic        nos_q, nos_d;

    logic        sel_vld;
    logic [1:0]  sel_idx;
    logic        changed;
    logic [3:0]  code;

    // Two-flop synchronizer for the asynchronous scan inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ssd_s1_q <= '0;
            ssd_s2_q <= '0;
            ctl_s1_q <= '0;
            ctl_s2_q <= '0;
        end else begin
            ssd_s1_q <= bus.D_ssd;
            ssd_s2_q <= ssd_s1_q;
            ctl_s1_q <= bus.D_ctl;
            ctl_s2_q <= ctl_s1_q;
        end
    end

    // A select is legal only with exactly one enable asserted (low).
    always_comb begin
        sel_vld = 1'b1;
        sel_idx = 2'd0;
        case (ctl_s2_q)
            4'b1110: sel_idx = 2'd0;
            4'b1101: sel_idx = 2'd1;
            4'b1011: sel_idx = 2'd2;
            4'b0111: sel_idx = 2'd3;
            default: sel_vld = 1'b0;
        endcase
    end

    assign changed = !sel_vld || (sel_idx != idx_q) || (ssd_s2_q != pat_q);
    assign code    = seg_decode(pat_q[7:1]);

    // Next state: stability FSM, staging/capture, frame publish, loss detection.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        pat_d      = pat_q;
        stg_code_d = stg_code_q;
        stg_dp_d   = stg_dp_q;
        cap_d      = cap_q;
        bcd_d      = bcd_q;
        dp_d       = dp_q;
        fd_d       = 1'b0;
        err_d      = err_q;
        nos_d      = nos_q;

        if (sel_vld)
            nosel_d = '0;
        else if (nosel_q == 16'hFFFF)
            nosel_d = nosel_q;
        else
            nosel_d = nosel_q + 16'd1;

        case (state_q)
            IDLE: begin
                if (sel_vld) begin
                    cnt_d   = 8'd1;
                    idx_d   = sel_idx;
                    pat_d   = ssd_s2_q;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (changed) begin
                    if (sel_vld) begin
                        cnt_d = 8'd1;
                        idx_d = sel_idx;
                        pat_d = ssd_s2_q;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == STABLE_W) begin
                        // Newest capture of a digit always overwrites its staging slot.
                        stg_code_d[{idx_q, 2'b00} +: 4] = code;
                        stg_dp_d[idx_q] = ~pat_q[0];
                        cap_d[idx_q]    = 1'b1;
                        if (code == 4'hE)
                            err_d = 1'b1;
                        state_d = HELD;
                    end
                end
            end
            HELD: begin
                // Leave only on a change; an unchanged digit is never recaptured.
                if (changed) begin
                    if (sel_vld) begin
                        cnt_d   = 8'd1;
                        idx_d   = sel_idx;
                        pat_d   = ssd_s2_q;
                        state_d = SETTLE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Publish in the same cycle the last capture bit lands.
        if (&cap_d) begin
            bcd_d = stg_code_d;
            dp_d  = stg_dp_d;
            fd_d  = 1'b1;
            cap_d = '0;
            nos_d = 1'b0;
        end

        // Loss of scan: drop the partial frame, keep the last published one.
        if (nosel_d >= TIMEOUT_W) begin
            nos_d   = 1'b1;
            cap_d   = '0;
            state_d = IDLE;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            pat_q      <= '0;
            stg_code_q <= '0;
            stg_dp_q   <= '0;
            cap_q      <= '0;
            nosel_q    <= '0;
            bcd_q      <= 16'hFFFF;
            dp_q       <= '0;
            fd_q       <= 1'b0;
            err_q      <= 1'b0;
            nos_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            pat_q      <= pat_d;
            stg_code_q <= stg_code_d;
            stg_dp_q   <= stg_dp_d;
            cap_q      <= cap_d;
            nosel_q    <= nosel_d;
            bcd_q      <= bcd_d;
            dp_q       <= dp_d;
            fd_q       <= fd_d;
            err_q      <= err_d;
            nos_q      <= nos_d;
        end
    end

    assign bus.bcd_out    = bcd_q;
    assign bus.dp_out     = dp_q;
    assign bus.frame_done = fd_q;
    assign bus.seg_err    = err_q;
    assign bus.no_signal  = nos_q;

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Scoreboard bench for ssd_scan_decoder: directed scans push expected frames,
// a negedge monitor pops and checks them whenever frame_done is seen.
module tb_ssd_scan_decoder;

    localparam int STABLE  = 4;
    localparam int TIMEOUT = 100;

    typedef struct {
        logic [15:0] bcd;
        logic [3:0]  dp;
        logic        seg;
    } exp_t;

    // a..g active-low patterns for digits 0..9
    localparam logic [6:0] SEGS [0:9] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] BAD   = 7'b1111110;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_set = 0;
    int   frames_seen = 0;
    int   frames_before;
    exp_t sb [$];
    exp_t e;

    ssd_scan_decoder_if bus ();

    ssd_scan_decoder #(
        .STABLE_CYC (STABLE),
        .TIMEOUT_CYC(TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] pat(input logic [6:0] s, input bit dp);
        return {s, ~dp};
    endfunction

    function automatic logic [7:0] dig(input int d, input bit dp);
        return pat(SEGS[d], dp);
    endfunction

    // Show pattern p on digit d for n cycles (inputs change 1 time unit after posedge).
    task automatic show(input int d, input logic [7:0] p, input int n);
        logic [3:0] one;
        one = 4'b0001 << d;
        bus.D_ctl = ~one;
        bus.D_ssd = p;
        last_set  = cyc;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.D_ctl = 4'b1111;
        bus.D_ssd = 8'hFF;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] b, input logic [3:0] d, input logic s);
        exp_t x;
        x.bcd = b;
        x.dp  = d;
        x.seg = s;
        sb.push_back(x);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_bcd"}, bus.bcd_out, 16'hFFFF);
        check({tag, "_dp"},  bus.dp_out, 4'h0);
        check({tag, "_fd"},  bus.frame_done, 1'b0);
        check({tag, "_seg"}, bus.seg_err, 1'b0);
        check({tag, "_nos"}, bus.no_signal, 1'b1);
    endtask

    // Monitor: every frame_done pulse must match the oldest expected frame.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.frame_done === 1'b1) begin
            frames_seen++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_frame: got frame_done=1 bcd=%h, required no frame", bus.bcd_out);
            end else begin
                e = sb.pop_front();
                check("frame_bcd", bus.bcd_out, e.bcd);
                check("frame_dp", bus.dp_out, e.dp);
                check("frame_seg", bus.seg_err, e.seg);
                check("frame_nos", bus.no_signal, 1'b0);
                check("frame_latency", cyc - last_set, STABLE + 2);
            end
        end
    end

    initial begin
        rst_n     = 1'b1;
        bus.D_ctl = 4'b1111;
        bus.D_ssd = 8'hFF;
        #3 rst_n = 1'b0;
        #1 check_reset_vals("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic frame 1,2,3,4 with dp on digit 2.
        push(16'h4321, 4'b0100, 1'b0);
        show(0, dig(1, 0), 16);
        show(1, dig(2, 0), 16);
        show(2, dig(3, 1), 16);
        show(3, dig(4, 0), 16);
        idle(20);
        check("frame1_drained", sb.size(), 0);
        check("frame1_count", frames_seen, 1);

        // Patterns held one cycle short of the threshold never capture.
        frames_before = frames_seen;
        for (int r = 0; r < 2; r++)
            for (int d = 0; d < 4; d++)
                show(d, dig(d + 5, 0), STABLE - 1);
        idle(10);
        check("short_hold_no_frame", frames_seen, frames_before);

        // Two simultaneous enables act as no select.
        bus.D_ctl = 4'b1100;
        bus.D_ssd = dig(8, 0);
        repeat (50) @(posedge clk);
        #1;
        idle(5);
        check("two_sel_no_frame", frames_seen, frames_before);
        check("two_sel_nos_kept", bus.no_signal, 1'b0);

        // Recapture of digit 1 before completion: newest value wins.
        push(16'h9785, 4'b0000, 1'b0);
        show(0, dig(5, 0), 16);
        show(1, dig(6, 0), 16);
        show(2, dig(7, 0), 16);
        show(1, dig(8, 0), 16);
        show(3, dig(9, 0), 16);
        idle(5);

        // Unknown pattern on digit 1, blank on digit 2.
        push(16'h3FE0, 4'b0001, 1'b1);
        show(0, dig(0, 1), 16);
        show(1, pat(BAD, 0), 16);
        show(2, pat(BLANK, 0), 16);
        show(3, dig(3, 0), 16);
        idle(5);

        // Clean frame afterwards: seg_err stays set.
        push(16'h4321, 4'b0000, 1'b1);
        show(0, dig(1, 0), 16);
        show(1, dig(2, 0), 16);
        show(2, dig(3, 0), 16);
        show(3, dig(4, 0), 16);

        // Loss of scan.
        idle(TIMEOUT + 10);
        check("loss_nos", bus.no_signal, 1'b1);
        check("loss_bcd_held", bus.bcd_out, 16'h4321);
        check("loss_dp_held", bus.dp_out, 4'h0);

        // Resume: no_signal holds until the next frame.
        push(16'h1098, 4'b0000, 1'b1);
        show(0, dig(8, 0), 16);
        show(1, dig(9, 0), 16);
        show(2, dig(0, 0), 16);
        check("resume_nos_before_frame", bus.no_signal, 1'b1);
        show(3, dig(1, 0), 16);
        check("resume_nos_after_frame", bus.no_signal, 1'b0);
        idle(5);

        // Reset mid-frame: asynchronous effect, then partial captures are gone.
        show(0, dig(2, 0), 16);
        show(1, dig(3, 0), 16);
        bus.D_ctl = 4'b1011;
        bus.D_ssd = dig(4, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #2 check_reset_vals("midreset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        frames_before = frames_seen;
        show(2, dig(4, 0), 16);
        show(3, dig(5, 0), 16);
        idle(10);
        check("midreset_no_frame", frames_seen, frames_before);
        idle(TIMEOUT + 10);

        push(16'h9876, 4'b0000, 1'b0);
        show(0, dig(6, 0), 16);
        show(1, dig(7, 0), 16);
        show(2, dig(8, 0), 16);
        show(3, dig(9, 0), 16);
        idle(10);

        check("final_drained", sb.size(), 0);
        check("final_frame_count", frames_seen, 6);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
